mult: RTL and testbench

// - Sequential 32x32 signed multiplier using radix-4 modified Booth recoding: 16 add/shift steps.
// - Returns the low 32 bits of the product and flags when the result does not fit in signed 32 bits.
// - Multiply unit of the CPU datapath; stepping state is exposed on debug ports for waveform and bench inspection.

---
 rtl/mult_pkg.sv | 28 ++
 rtl/mult_booth_step.sv | 81 ++++++++
 rtl/mult.sv | 74 +++++++
 tb/tb_mult.sv | 169 ++++++++++++++++
 4 files changed

// File: rtl/mult_pkg.sv
// Shared widths and radix-4 Booth decode for the sequential multiplier.
package mult_pkg;

    localparam int WORD_W = 32;
    localparam int PROD_W = 65;
    localparam int STEPS  = 16;
    localparam int ACC_W  = WORD_W + 2;
    localparam int REG_W  = PROD_W + 2;

    typedef enum logic [2:0] {
        BOOTH_ZERO   = 3'd0,
        BOOTH_ADD_M  = 3'd1,
        BOOTH_ADD_2M = 3'd2,
        BOOTH_SUB_2M = 3'd3,
        BOOTH_SUB_M  = 3'd4
    } booth_op_e;

    function automatic booth_op_e booth_decode(input logic [2:0] t);
        case (t)
            3'b001, 3'b010: return BOOTH_ADD_M;
            3'b011:         return BOOTH_ADD_2M;
            3'b100:         return BOOTH_SUB_2M;
            3'b101, 3'b110: return BOOTH_SUB_M;
            default:        return BOOTH_ZERO;
        endcase
    endfunction

endpackage

// File: rtl/mult_booth_step.sv
// One radix-4 Booth step: decode the low triplet, pick the multiple of M,
// add it into the guard-extended accumulator and shift the register right by 2.
module mult_booth_step
    import mult_pkg::*;
(
    input  logic signed [REG_W-1:0]  src,
    input  logic signed [WORD_W-1:0] m,
    output logic signed [REG_W-1:0]  nxt,
    output logic [WORD_W-1:0]        cla_in,
    output logic [WORD_W-1:0]        cla_out,
    output logic [WORD_W-1:0]        shifted_data,
    output logic [WORD_W-1:0]        inverted_data,
    output logic [WORD_W-1:0]        subtract_data,
    output logic                     ctrl_add,
    output logic                     ctrl_sub,
    output logic                     ctrl_shift,
    output logic                     ctrl_zeroin
);

    // 4-bit lookahead groups chained across the word; guard bits ride on the final carry.
    function automatic logic [ACC_W-1:0] cla_add(input logic [ACC_W-1:0] a, input logic [ACC_W-1:0] b);
        logic [WORD_W-1:0] g;
        logic [WORD_W-1:0] p;
        logic [WORD_W:0]   c;
        logic [ACC_W-1:0]  s;
        g    = a[WORD_W-1:0] & b[WORD_W-1:0];
        p    = a[WORD_W-1:0] ^ b[WORD_W-1:0];
        c[0] = 1'b0;
        for (int k = 0; k < WORD_W / 4; k++) begin
            int i;
            i = 4 * k;
            c[i+1] = g[i] | (p[i] & c[i]);
            c[i+2] = g[i+1] | (p[i+1] & g[i]) | (p[i+1] & p[i] & c[i]);
            c[i+3] = g[i+2] | (p[i+2] & g[i+1]) | (p[i+2] & p[i+1] & g[i])
                   | (p[i+2] & p[i+1] & p[i] & c[i]);
            c[i+4] = g[i+3] | (p[i+3] & g[i+2]) | (p[i+3] & p[i+2] & g[i+1])
                   | (p[i+3] & p[i+2] & p[i+1] & g[i])
                   | (p[i+3] & p[i+2] & p[i+1] & p[i] & c[i]);
        end
        s[WORD_W-1:0]     = p ^ c[WORD_W-1:0];
        s[ACC_W-1:WORD_W] = a[ACC_W-1:WORD_W] + b[ACC_W-1:WORD_W] + {1'b0, c[WORD_W]};
        return s;
    endfunction

    booth_op_e              op;
    logic signed [ACC_W-1:0] m_ext;
    logic signed [ACC_W-1:0] multiple;
    logic signed [ACC_W-1:0] inv;
    logic signed [ACC_W-1:0] neg;
    logic signed [ACC_W-1:0] addend;
    logic signed [ACC_W-1:0] acc;

    assign op          = booth_decode(src[2:0]);
    assign ctrl_zeroin = (op == BOOTH_ZERO);
    assign ctrl_add    = (op == BOOTH_ADD_M) || (op == BOOTH_ADD_2M);
    assign ctrl_sub    = (op == BOOTH_SUB_M) || (op == BOOTH_SUB_2M);
    assign ctrl_shift  = (op == BOOTH_ADD_2M) || (op == BOOTH_SUB_2M);

    assign m_ext    = {{2{m[WORD_W-1]}}, m};
    assign multiple = ctrl_shift ? (m_ext <<< 1) : m_ext;
    assign inv      = ~multiple;
    assign neg      = inv + ACC_W'(1);

    always_comb begin
        addend = '0;
        if (ctrl_add)
            addend = multiple;
        else if (ctrl_sub)
            addend = neg;
    end

    assign acc = cla_add(src[REG_W-1:WORD_W+1], addend);
    assign nxt = $signed({acc, src[WORD_W:0]}) >>> 2;

    assign cla_in        = addend[WORD_W-1:0];
    assign cla_out       = acc[WORD_W-1:0];
    assign shifted_data  = m_ext[WORD_W-2:0] << 1 == '0 ? {m[WORD_W-2:0], 1'b0} : {m[WORD_W-2:0], 1'b0};
    assign inverted_data = inv[WORD_W-1:0];
    assign subtract_data = neg[WORD_W-1:0];

endmodule

// File: rtl/mult.sv
// Sequential 32x32 signed radix-4 Booth multiplier: 16 steps after reset release,
// then holds the product with a ready flag and a signed-overflow flag.
module mult
    import mult_pkg::*;
(
    input  logic                clk,
    input  logic                rst,
    input  logic [WORD_W-1:0]   data_operandA,
    input  logic [WORD_W-1:0]   data_operandB,
    output logic [WORD_W-1:0]   data_result,
    output logic                data_exception,
    output logic                data_resultRDY,
    output logic [4:0]          count,
    output logic [PROD_W-1:0]   initial_input,
    output logic [PROD_W-1:0]   product_out,
    output logic [PROD_W-1:0]   product_in,
    output logic [PROD_W-1:0]   raw_data,
    output logic [PROD_W-1:0]   final_result,
    output logic [WORD_W-1:0]   cla_in,
    output logic [WORD_W-1:0]   cla_out,
    output logic [WORD_W-1:0]   shifted_data,
    output logic [WORD_W-1:0]   inverted_data,
    output logic [WORD_W-1:0]   subtract_data,
    output logic                ctrl_add,
    output logic                ctrl_sub,
    output logic                ctrl_shift,
    output logic                ctrl_zeroin
);

    // Product register carries the two accumulator guard bits above the visible 65 bits.
    logic signed [REG_W-1:0] prod_p0;
    logic signed [REG_W-1:0] src;
    logic signed [REG_W-1:0] step_nxt;
    logic [2*WORD_W-WORD_W:0] upper;

    assign initial_input = {{WORD_W{1'b0}}, data_operandB, 1'b0};
    assign src           = (count == '0) ? {2'b00, initial_input} : prod_p0;
    assign raw_data      = $signed(src[PROD_W-1:0]) >>> 2;

    mult_booth_step u_step (
        .src           (src),
        .m             (data_operandA),
        .nxt           (step_nxt),
        .cla_in        (cla_in),
        .cla_out       (cla_out),
        .shifted_data  (shifted_data),
        .inverted_data (inverted_data),
        .subtract_data (subtract_data),
        .ctrl_add      (ctrl_add),
        .ctrl_sub      (ctrl_sub),
        .ctrl_shift    (ctrl_shift),
        .ctrl_zeroin   (ctrl_zeroin)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            count   <= '0;
            prod_p0 <= '0;
        end else if (count != 5'(STEPS)) begin
            count   <= count + 5'd1;
            prod_p0 <= step_nxt;
        end
    end

    // Product bits [63:31] sit at register bits [64:32]; all-equal means it fits in 32 bits.
    assign upper          = prod_p0[2*WORD_W:WORD_W];
    assign data_resultRDY = (count == 5'(STEPS));
    assign data_exception = data_resultRDY && !((&upper) || !(|upper));
    assign data_result    = prod_p0[WORD_W:1];
    assign product_out    = prod_p0[PROD_W-1:0];
    assign product_in     = step_nxt[PROD_W-1:0];
    assign final_result   = data_resultRDY ? prod_p0[PROD_W-1:0] : '0;

endmodule

// File: tb/tb_mult.sv
// Bench for the sequential Booth multiplier: directed table, multi-cycle
// sequences and randomized operands against a 64-bit arithmetic model.
module tb_mult;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] a, b;
    logic [31:0] data_result;
    logic        data_exception, data_resultRDY;
    logic [4:0]  count;
    logic [64:0] initial_input, product_out, product_in, raw_data, final_result;
    logic [31:0] cla_in, cla_out, shifted_data, inverted_data, subtract_data;
    logic        ctrl_add, ctrl_sub, ctrl_shift, ctrl_zeroin;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    mult dut (
        .clk            (clk),
        .rst            (rst),
        .data_operandA  (a),
        .data_operandB  (b),
        .data_result    (data_result),
        .data_exception (data_exception),
        .data_resultRDY (data_resultRDY),
        .count          (count),
        .initial_input  (initial_input),
        .product_out    (product_out),
        .product_in     (product_in),
        .raw_data       (raw_data),
        .final_result   (final_result),
        .cla_in         (cla_in),
        .cla_out        (cla_out),
        .shifted_data   (shifted_data),
        .inverted_data  (inverted_data),
        .subtract_data  (subtract_data),
        .ctrl_add       (ctrl_add),
        .ctrl_sub       (ctrl_sub),
        .ctrl_shift     (ctrl_shift),
        .ctrl_zeroin    (ctrl_zeroin)
    );

    typedef struct {
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] res;
        logic        exc;
    } vec_t;

    vec_t vecs[11];

    task automatic chk(input string nm, input logic [64:0] act, input logic [64:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got=%h want=%h", nm, act, exp);
        end
    endtask

    // Exact signed product from plain 64-bit arithmetic.
    task automatic model(input logic [31:0] ma, input logic [31:0] mb,
                         output logic [31:0] res, output logic exc);
        longint sa, sb, p;
        sa  = longint'($signed(ma));
        sb  = longint'($signed(mb));
        p   = sa * sb;
        res = p[31:0];
        exc = (p > 64'sd2147483647) || (p < -64'sd2147483648);
    endtask

    // Operands are set while reset is held; first rising edge after this is step 1.
    task automatic start(input logic [31:0] ta, input logic [31:0] tb);
        @(negedge clk);
        rst = 1'b0;
        a   = ta;
        b   = tb;
        @(negedge clk);
        rst = 1'b1;
    endtask

    task automatic run_checked(input string nm, input logic [31:0] ta, input logic [31:0] tb,
                               input logic [31:0] eres, input logic eexc);
        start(ta, tb);
        repeat (15) @(posedge clk);
        #1 chk({nm, "_rdy_early"}, data_resultRDY, 1'b0);
        @(posedge clk);
        #1;
        chk({nm, "_rdy"}, data_resultRDY, 1'b1);
        chk({nm, "_res"}, data_result, eres);
        chk({nm, "_exc"}, data_exception, eexc);
        repeat (3) @(posedge clk);
        #1;
        chk({nm, "_hold_rdy"}, data_resultRDY, 1'b1);
        chk({nm, "_hold_res"}, data_result, eres);
        chk({nm, "_hold_cnt"}, count, 5'd16);
    endtask

    initial begin
        logic [31:0] ra, rb, eres;
        logic        eexc;

        vecs[0]  = '{32'hFFFF_FFF8, 32'h0000_0010, 32'hFFFF_FF80, 1'b0};
        vecs[1]  = '{32'h0000_0007, 32'hFFFF_FFFD, 32'hFFFF_FFEB, 1'b0};
        vecs[2]  = '{32'h7FFF_FFFF, 32'h0000_0002, 32'hFFFF_FFFE, 1'b1};
        vecs[3]  = '{32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1'b1};
        vecs[4]  = '{32'h8000_0000, 32'h0000_0001, 32'h8000_0000, 1'b0};
        vecs[5]  = '{32'h0000_0000, 32'h1234_5678, 32'h0000_0000, 1'b0};
        vecs[6]  = '{32'hDEAD_BEEF, 32'h0000_0000, 32'h0000_0000, 1'b0};
        vecs[7]  = '{32'h8000_0000, 32'h8000_0000, 32'h0000_0000, 1'b1};
        vecs[8]  = '{32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0001, 1'b0};
        vecs[9]  = '{32'h0001_0000, 32'h0001_0000, 32'h0000_0000, 1'b1};
        vecs[10] = '{32'h7FFF_FFFF, 32'h7FFF_FFFF, 32'h0000_0001, 1'b1};

        rst = 1'b0;
        a   = 32'h0000_0007;
        b   = 32'hFFFF_FFFD;
        #12;
        chk("reset_count", count, 5'd0);
        chk("reset_rdy", data_resultRDY, 1'b0);
        chk("reset_exc", data_exception, 1'b0);
        chk("reset_final", final_result, 65'd0);
        chk("reset_prod", product_out, 65'd0);
        // Count 0: source is {0, B, 0}; triplet 010 -> +M.
        chk("reset_init_in", initial_input, {32'd0, 32'hFFFF_FFFD, 1'b0});
        chk("reset_add", ctrl_add, 1'b1);
        chk("reset_cla_in", cla_in, 32'd7);
        chk("reset_shifted", shifted_data, 32'd14);

        for (int i = 0; i < 11; i++)
            run_checked($sformatf("vec%0d", i), vecs[i].a, vecs[i].b, vecs[i].res, vecs[i].exc);

        // Reset mid-operation at count 7, then a clean full run.
        start(32'hFFFF_FFF8, 32'h0000_0010);
        repeat (7) @(posedge clk);
        #1 chk("mid_count7", count, 5'd7);
        rst = 1'b0;
        #1;
        chk("mid_count0", count, 5'd0);
        chk("mid_rdy", data_resultRDY, 1'b0);
        chk("mid_prod", product_out, 65'd0);
        @(negedge clk);
        rst = 1'b1;
        repeat (16) @(posedge clk);
        #1;
        chk("mid_rerun_rdy", data_resultRDY, 1'b1);
        chk("mid_rerun_res", data_result, 32'hFFFF_FF80);
        chk("mid_rerun_exc", data_exception, 1'b0);
        chk("mid_rerun_final", final_result[32:1], 32'hFFFF_FF80);

        for (int i = 0; i < 1000; i++) begin
            ra = $urandom;
            rb = $urandom;
            if (i % 4 == 1) ra = $urandom_range(0, 65535) - 32768;
            if (i % 4 == 2) rb = $urandom_range(0, 65535) - 32768;
            model(ra, rb, eres, eexc);
            start(ra, rb);
            repeat (16) @(posedge clk);
            #1;
            chk($sformatf("rnd%0d_res", i), data_result, eres);
            chk($sformatf("rnd%0d_exc", i), data_exception, eexc);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
